// File: rtl/tno_tobm_pkg.sv
// Shared types for the TNO/TOBM timing generator: FSM states, default field
// widths and the latched configuration record with its clamping rule.
package tno_tobm_pkg;

    localparam int TNO_CNT_W = 16;
    localparam int TNO_WID_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        TNO_HI,
        BURST_HI,
        BURST_LO
    } state_t;

    typedef struct packed {
        logic [TNO_CNT_W-1:0] delay;
        logic [TNO_WID_W-1:0] width;
        logic [TNO_CNT_W-1:0] period;
        logic [TNO_WID_W-1:0] count;
    } cfg_t;

    // Width 0 becomes 1; period is raised so every burst pulse has a low phase.
    function automatic cfg_t clamp_cfg(input logic [TNO_CNT_W-1:0] d,
                                       input logic [TNO_WID_W-1:0] w,
                                       input logic [TNO_CNT_W-1:0] p,
                                       input logic [TNO_WID_W-1:0] n);
        cfg_t c;
        logic [TNO_CNT_W-1:0] p_min;
        c.delay  = d;
        c.count  = n;
        c.width  = (w == '0) ? TNO_WID_W'(1) : w;
        p_min    = TNO_CNT_W'(c.width) + TNO_CNT_W'(1);
        c.period = (p < p_min) ? p_min : p;
        return c;
    endfunction

endpackage

// File: rtl/tnc_sync_edge.sv
// Two-flop synchroniser for an asynchronous strobe followed by a rising-edge
// detector; start is a single-cycle pulse per detected rising edge.
module tnc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/tno_tobm_gen.sv
// Per accepted TNC edge: one TNO pulse after a programmable delay, then a
// programmable burst of TOBM pulses. Config is captured at start and clamped.
module tno_tobm_gen
    import tno_tobm_pkg::*;
#(
    parameter int CNT_W = TNO_CNT_W,
    parameter int WID_W = TNO_WID_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tnc,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [WID_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [WID_W-1:0] cfg_count,
    output logic             tnc_o,
    output logic             tno,
    output logic             tobm,
    output logic             busy,
    output logic             err_overlap
);

    logic             start;
    state_t           state, state_nxt;
    cfg_t             cfg_in, cfg_q;
    logic             cfg_ld;
    logic [CNT_W-1:0] dly_cnt, dly_nxt;
    logic [WID_W-1:0] wid_cnt, wid_nxt;
    logic [WID_W-1:0] rem_cnt, rem_nxt;

    assign tnc_o  = tnc;
    assign cfg_in = clamp_cfg(cfg_delay, cfg_width, cfg_period, cfg_count);

    tnc_sync_edge u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (tnc),
        .rise (start)
    );

    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        wid_nxt   = wid_cnt;
        rem_nxt   = rem_cnt;
        cfg_ld    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cfg_ld  = 1'b1;
                    rem_nxt = cfg_in.count;
                    if (cfg_in.delay == '0) begin
                        state_nxt = TNO_HI;
                        wid_nxt   = cfg_in.width - WID_W'(1);
                    end else begin
                        state_nxt = DELAY;
                        dly_nxt   = cfg_in.delay - CNT_W'(1);
                    end
                end
            end
            DELAY: begin
                if (dly_cnt == '0) begin
                    state_nxt = TNO_HI;
                    wid_nxt   = cfg_q.width - WID_W'(1);
                end else begin
                    dly_nxt = dly_cnt - CNT_W'(1);
                end
            end
            TNO_HI: begin
                if (wid_cnt != '0) begin
                    wid_nxt = wid_cnt - WID_W'(1);
                end else if (rem_cnt != '0) begin
                    state_nxt = BURST_HI;
                    wid_nxt   = cfg_q.width - WID_W'(1);
                    rem_nxt   = rem_cnt - WID_W'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            BURST_HI: begin
                // The last pulse ends the sequence with no trailing low phase.
                if (wid_cnt != '0) begin
                    wid_nxt = wid_cnt - WID_W'(1);
                end else if (rem_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = BURST_LO;
                    dly_nxt   = cfg_q.period - CNT_W'(cfg_q.width) - CNT_W'(1);
                end
            end
            BURST_LO: begin
                if (dly_cnt == '0) begin
                    state_nxt = BURST_HI;
                    wid_nxt   = cfg_q.width - WID_W'(1);
                    rem_nxt   = rem_cnt - WID_W'(1);
                end else begin
                    dly_nxt = dly_cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dly_cnt     <= '0;
            wid_cnt     <= '0;
            rem_cnt     <= '0;
            tno         <= 1'b0;
            tobm        <= 1'b0;
            busy        <= 1'b0;
            err_overlap <= 1'b0;
        end else begin
            state       <= state_nxt;
            dly_cnt     <= dly_nxt;
            wid_cnt     <= wid_nxt;
            rem_cnt     <= rem_nxt;
            tno         <= (state_nxt == TNO_HI);
            tobm        <= (state_nxt == BURST_HI);
            busy        <= (state_nxt != IDLE);
            err_overlap <= start && (state != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_ld) begin
            cfg_q <= cfg_in;
        end
    end

endmodule

// File: tb/tb_tno_tobm_gen.sv
// Scoreboard bench: each tnc edge yields a list of expected output toggle
// cycles computed from the timing rules; a monitor matches observed toggles.
module tb_tno_tobm_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tnc = 1'b0;
    logic [15:0] cfg_delay = '0;
    logic [7:0]  cfg_width = '0;
    logic [15:0] cfg_period = '0;
    logic [7:0]  cfg_count = '0;
    logic        tnc_o, tno, tobm, busy, err_overlap;

    tno_tobm_gen #(.CNT_W(16), .WID_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tnc        (tnc),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_period (cfg_period),
        .cfg_count  (cfg_count),
        .tnc_o      (tnc_o),
        .tno        (tno),
        .tobm       (tobm),
        .busy       (busy),
        .err_overlap(err_overlap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int last_fall = 0;
    int q_tno[$];
    int q_tobm[$];
    int q_busy[$];
    int q_err[$];
    logic p_tno = 1'b0, p_tobm = 1'b0, p_busy = 1'b0, p_err = 1'b0;
    string names[4] = '{"tno", "tobm", "busy", "err_overlap"};

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a start at edge k is accepted iff the previous sequence's
    // busy has fallen by edge k+1; everything else follows from D, W, P, N.
    task automatic model_start(input int k);
        int d, w, p, n, t0, fin;
        d = int'(cfg_delay);
        w = (cfg_width == 0) ? 1 : int'(cfg_width);
        p = int'(cfg_period);
        if (p < w + 1) p = w + 1;
        n = int'(cfg_count);
        if (k + 1 >= last_fall) begin
            q_busy.push_back(k + 2);
            q_tno.push_back(k + 2 + d);
            q_tno.push_back(k + 2 + d + w);
            fin = k + 2 + d + w;
            for (int i = 0; i < n; i++) begin
                t0 = k + 2 + d + w + i * p;
                q_tobm.push_back(t0);
                q_tobm.push_back(t0 + w);
                fin = t0 + w;
            end
            q_busy.push_back(fin);
            last_fall = fin;
        end else begin
            q_err.push_back(k + 2);
            q_err.push_back(k + 3);
        end
    endtask

    task automatic on_toggle(input int s);
        int e;
        e = -1;
        case (s)
            0: if (q_tno.size() > 0) e = q_tno.pop_front();
            1: if (q_tobm.size() > 0) e = q_tobm.pop_front();
            2: if (q_busy.size() > 0) e = q_busy.pop_front();
            default: if (q_err.size() > 0) e = q_err.pop_front();
        endcase
        check({names[s], " toggle cycle"}, cyc, e);
    endtask

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (!rst_n) begin
            p_tno = 1'b0; p_tobm = 1'b0; p_busy = 1'b0; p_err = 1'b0;
        end else begin
            if (tno !== p_tno) on_toggle(0);
            if (tobm !== p_tobm) on_toggle(1);
            if (busy !== p_busy) on_toggle(2);
            if (err_overlap !== p_err) on_toggle(3);
            p_tno = tno; p_tobm = tobm; p_busy = busy; p_err = err_overlap;
        end
    end

    task automatic set_cfg(input int d, input int w, input int p, input int n);
        cfg_delay  = 16'(d);
        cfg_width  = 8'(w);
        cfg_period = 16'(p);
        cfg_count  = 8'(n);
    endtask

    // tnc is raised just before edge k, held for h edges, then low for two.
    task automatic pulse(input int h);
        @(negedge clk);
        tnc = 1'b1;
        model_start(cyc + 1);
        #1 check("tnc_o high", int'(tnc_o), 1);
        repeat (h) @(negedge clk);
        tnc = 1'b0;
        #1 check("tnc_o low", int'(tnc_o), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input int max);
        int t;
        t = 0;
        while ((q_tno.size() + q_tobm.size() + q_busy.size() + q_err.size()) != 0 && t < max) begin
            @(negedge clk);
            t++;
        end
        check("pending events", q_tno.size() + q_tobm.size() + q_busy.size() + q_err.size(), 0);
        check("busy after drain", int'(busy), 0);
    endtask

    task automatic reset_mid();
        int t;
        t = 0;
        while (tobm !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reached burst", int'(tobm === 1'b1), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst tno", int'(tno), 0);
        check("rst tobm", int'(tobm), 0);
        check("rst busy", int'(busy), 0);
        check("rst err", int'(err_overlap), 0);
        q_tno.delete(); q_tobm.delete(); q_busy.delete(); q_err.delete();
        last_fall = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset tno", int'(tno), 0);
        check("reset tobm", int'(tobm), 0);
        check("reset busy", int'(busy), 0);
        check("reset err", int'(err_overlap), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        set_cfg(5, 3, 10, 4);  pulse(4); drain(300);
        set_cfg(0, 0, 0, 0);   pulse(2); drain(300);
        set_cfg(3, 4, 2, 3);   pulse(3); drain(300);
        set_cfg(20, 3, 5, 2);  pulse(2); @(negedge clk); pulse(2); drain(300);
        set_cfg(5, 2, 4, 1);   pulse(2); cfg_delay = 16'd50; drain(300);
        set_cfg(2, 3, 8, 5);   pulse(2); reset_mid();
        set_cfg(4, 2, 6, 2);   pulse(3); drain(300);

        for (int i = 0; i < 40; i++) begin
            set_cfg($urandom_range(0, 15), $urandom_range(0, 5),
                    $urandom_range(0, 15), $urandom_range(0, 4));
            pulse($urandom_range(2, 4));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                pulse(2);
            end
            set_cfg($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        drain(5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tno_tobm_gen.md
# tno_tobm_gen

Upstream timing generator for the sync-signal path. It takes the external cycle-start strobe TNC and produces the two candidate sync pulses, TNO and TOBM, that the downstream selector switches onto SIG. For each accepted TNC rising edge, the block emits one TNO pulse after a programmable delay, followed by a programmable burst of TOBM pulses. It also forwards TNC unchanged for downstream use.

## Interface
Parameters:
- CNT_W, 16, width of the delay and period counters
- WID_W, 8, width of the pulse-width and burst-count fields

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- tnc  in  1  cycle-start strobe, asynchronous to clk
- cfg_delay  in  CNT_W  cycles from start detect to TNO rise (D)
- cfg_width  in  WID_W  high time of TNO and of each TOBM pulse (W); 0 is treated as 1
- cfg_period  in  CNT_W  spacing between TOBM rising edges (P); clamped to at least W+1
- cfg_count  in  WID_W  number of TOBM pulses (N); 0 means no burst
- tnc_o  out  1  combinational copy of tnc
- tno  out  1  registered TNO pulse
- tobm  out  1  registered TOBM pulse
- busy  out  1  high from accepted start to end of the sequence
- err_overlap  out  1  one-cycle pulse when a TNC edge arrives while busy

## Operation
- **Input synchronisation.** tnc passes through two flops (s1, s2) and a third edge flop (s3). The internal start signal is s2 & ~s3.
- **Config latch.** On an accepted start, cfg_* are latched into internal shadow registers. Changes to cfg_* during a sequence have no effect until the next start.
- **State machine.** States: IDLE, DELAY, TNO_HI, BURST_HI, BURST_LO.
  - IDLE: on start, go to TNO_HI if D=0, else to DELAY with the counter loaded to D-1.
  - DELAY: count down. At 0, go to TNO_HI with the counter loaded to W-1.
  - TNO_HI: tno=1. At count 0, go to BURST_HI if N>0, else to IDLE.
  - BURST_HI: tobm=1 for W cycles. Then go to BURST_LO for P-W cycles.
  - BURST_LO: after the last pulse, go directly to IDLE; no trailing low phase.
- **Counting.** A remaining-pulse counter is loaded with N and decrements on each BURST_HI entry. All counters are unsigned and never wrap. Clamping (W=0→1, P<W+1 → P=W+1) is applied when the config is latched.
- **Overlap.** A start detected while the FSM is not in IDLE is ignored. err_overlap pulses for one cycle and the sequence continues unchanged.
- **Busy.** busy = (state != IDLE), registered together with the state.
- **Reset.** Asynchronous assertion of rst_n, including mid-sequence, forces:
  - state to IDLE;
  - tno, tobm, busy and err_overlap to 0;
  - all counters and synchroniser flops to 0.
  - After release, a tnc that is already high is seen as an edge once s2 rises.

## Timing
- Let k be the first clk edge at which s1 samples tnc=1.
- The start signal is true in the cycle after edge k+1.
- The FSM leaves IDLE at edge k+2. busy rises at k+2.
- tno rises at edge k+2+D and falls at k+2+D+W.
- The first tobm rise is at k+2+D+W, the same edge where tno falls, so there is no gap and no overlap.
- Pulse i (0-based) rises at k+2+D+W+i·P and falls W cycles later.
- busy falls on the edge where the last tobm falls; with N=0, it falls where tno falls.
- A new start is accepted in the cycle immediately after busy falls.
- tnc_o has zero latency (combinational).
- A tnc high pulse must last at least 2 clk periods to be guaranteed detection. Shorter pulses may be missed; this is legal.

## Structure
- **Package tno_tobm_pkg:**
  - state enum (IDLE, DELAY, TNO_HI, BURST_HI, BURST_LO);
  - default CNT_W and WID_W localparams;
  - a struct grouping the latched cfg fields.
- **Sub-module tnc_sync_edge:** 2-flop synchroniser plus rising-edge detector, with clk and rst_n. It is reused elsewhere for other external strobes.
- **Top level:** contains the FSM, the three counters and the output registers.

## Test plan
- D=5, W=3, P=10, N=4, single tnc pulse of 4 clks:
  - tno high on edges k+7..k+9;
  - tobm rises at k+10, k+20, k+30, k+40, each 3 cycles wide;
  - busy falls at k+43.
- D=0, W=0, N=0: tno is high for exactly 1 cycle at edge k+2; tobm never toggles; busy is high for 1 cycle.
- P=2 with W=4 (clamp): tobm pulses are 4 cycles high with P forced to 5, i.e. 1 low cycle between pulses.
- Second tnc edge arriving 6 cycles into a D=20 sequence: err_overlap pulses once, and tno timing matches the first edge only.
- cfg_delay changed from 5 to 50 during DELAY: tno still rises at k+7.
- rst_n asserted during BURST_HI: tno, tobm and busy go to 0 immediately. After release, a fresh tnc edge produces a complete, correctly timed sequence.
